// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect the five push-buttons; define AUTO_REPEAT_EN
// to add hold-to-auto-repeat press pulses on the channels selected by REPEAT_MASK.
module button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 40000,
  parameter int unsigned HOLD_CYCLES     = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 200000,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(5'b01100)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_async,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] syncMeta;
  logic [N_BTN-1:0] syncOut;
  logic [N_BTN-1:0] lvl;
  logic [CntW-1:0]  cnt [N_BTN];
  logic [N_BTN-1:0] rptFire;

  // Two-flop synchroniser feeding a per-channel stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta <= '0;
      syncOut  <= '0;
      lvl      <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      syncMeta <= btn_async;
      syncOut  <= syncMeta;
      for (int i = 0; i < N_BTN; i++) begin
        if (syncOut[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntMax) begin
          lvl[i] <= ~lvl[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CntW'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RptSpan = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RcntW   = (RptSpan > 1) ? $clog2(RptSpan) : 1;
  localparam logic [RcntW-1:0] HoldMax = RcntW'(HOLD_CYCLES - 1);
  localparam logic [RcntW-1:0] RepMax  = RcntW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rptState_t;

  rptState_t        rptState [N_BTN];
  logic [RcntW-1:0] rcnt     [N_BTN];

  // A repeat fires on the cycle its counter hits the compare point while still pressed
  always_comb begin
    rptFire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rptFire[i] = lvl[i] && (((rptState[i] == HOLD) && (rcnt[i] == HoldMax)) ||
                              ((rptState[i] == REPEAT) && (rcnt[i] == RepMax)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        rptState[i] <= IDLE;
        rcnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!REPEAT_MASK[i] || !lvl[i]) begin
          rptState[i] <= IDLE;
          rcnt[i]     <= '0;
        end else begin
          case (rptState[i])
            IDLE: begin
              // lvl high while still idle only happens on the rising cycle
              rptState[i] <= HOLD;
              rcnt[i]     <= '0;
            end
            HOLD: begin
              if (rcnt[i] == HoldMax) begin
                rptState[i] <= REPEAT;
                rcnt[i]     <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + RcntW'(1);
              end
            end
            REPEAT: begin
              if (rcnt[i] == RepMax) rcnt[i] <= '0;
              else                   rcnt[i] <= rcnt[i] + RcntW'(1);
            end
            default: begin
              rptState[i] <= IDLE;
              rcnt[i]     <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  assign rptFire = '0;
`endif

  // Output stage: level plus one-cycle edge pulses, all aligned to the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_level   <= lvl;
      btn_press   <= (lvl & ~btn_level) | (rptFire & REPEAT_MASK);
      btn_release <= ~lvl & btn_level;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// checked every cycle against a sample-window reference model.
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam logic [N-1:0] MASK = 5'b01100;
  localparam int MAXC = 16384;
`ifdef AUTO_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_async;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int passCnt = 0;
  int totalCnt = 0;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .btn_async(btn_async),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    totalCnt++;
    if (act !== exp) $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
    else passCnt++;
  endtask

  // Reference model: level flips once the last DB raw samples (seen 3 edges ago
  // through sync + output stages) all disagree with it; repeats are pure arithmetic.
  logic [N-1:0] samp [0:MAXC-1];
  int           cyc = 0;
  logic [N-1:0] mLevel = '0;
  logic [N-1:0] mPress = '0;
  logic [N-1:0] mRelease = '0;
  int           riseAt [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      mLevel = '0;
      mPress = '0;
      mRelease = '0;
    end else begin
      if (cyc < MAXC) samp[cyc] = btn_async;
      mPress = '0;
      mRelease = '0;
      for (int ch = 0; ch < N; ch++) begin
        bit allDiff;
        allDiff = 1'b1;
        for (int k = cyc - 2 - DB; k <= cyc - 3; k++) begin
          logic [N-1:0] s;
          s = (k >= 0) ? samp[k] : '0;
          if (s[ch] == mLevel[ch]) allDiff = 1'b0;
        end
        if (allDiff) begin
          mLevel[ch] = ~mLevel[ch];
          if (mLevel[ch]) begin
            mPress[ch] = 1'b1;
            riseAt[ch] = cyc;
          end else begin
            mRelease[ch] = 1'b1;
          end
        end else if (RPT && MASK[ch] && mLevel[ch]) begin
          int held;
          held = cyc - riseAt[ch];
          if (held >= HOLD && ((held - HOLD) % REP) == 0) mPress[ch] = 1'b1;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    check("level", btn_level, mLevel);
    check("press", btn_press, mPress);
    check("release", btn_release, mRelease);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Hold one button for n cycles, release, and count pulses on that channel
  task automatic holdCount(input int ch, input int n, output int presses, output int releases);
    presses = 0;
    releases = 0;
    btn_async[ch] = 1'b1;
    for (int i = 0; i < n + 12; i++) begin
      if (i == n) btn_async[ch] = 1'b0;
      tick(1);
      if (btn_press[ch]) presses++;
      if (btn_release[ch]) releases++;
    end
  endtask

  initial begin
    int pc;
    int rc;
    reset = 1'b1;
    btn_async = '0;
    tick(3);
    reset = 1'b0;
    tick(5);
    check("reset_outputs", btn_level | btn_press | btn_release, 5'b00000);

    // Clean press on mode
    btn_async[0] = 1'b1;
    tick(6);
    check("clean_early", btn_level, 5'b00000);
    tick(1);
    check("clean_level", btn_level, 5'b00001);
    check("clean_press", btn_press, 5'b00001);
    tick(1);
    check("clean_single", btn_press, 5'b00000);
    btn_async[0] = 1'b0;
    tick(12);

    // Bounce on set
    btn_async[1] = 1'b1;
    tick(3);
    btn_async[1] = 1'b0;
    tick(1);
    btn_async[1] = 1'b1;
    tick(6);
    check("bounce_early", btn_press | btn_level, 5'b00000);
    tick(1);
    check("bounce_press", btn_press, 5'b00010);
    btn_async[1] = 1'b0;
    tick(12);

    // Long hold on repeat-eligible and non-eligible channels
    holdCount(2, 30, pc, rc);
    check("repeat_presses", 5'(pc), RPT ? 5'd8 : 5'd1);
    check("repeat_release", 5'(rc), 5'd1);
    holdCount(0, 30, pc, rc);
    check("norepeat_presses", 5'(pc), 5'd1);
    check("norepeat_release", 5'(rc), 5'd1);

    // Reset while op2 is deep into its hold
    btn_async[3] = 1'b1;
    tick(6 + 1 + HOLD + 2);
    check("midhold_level", btn_level, 5'b01000);
    reset = 1'b1;
    #1;
    check("midhold_reset", btn_level | btn_press | btn_release, 5'b00000);
    tick(1);
    reset = 1'b0;
    tick(6);
    check("postreset_early", btn_level, 5'b00000);
    tick(1);
    check("postreset_press", btn_press, 5'b01000);
    btn_async[3] = 1'b0;
    tick(12);

    // Simultaneous press on op1, op2 and free
    btn_async = 5'b11100;
    tick(7);
    check("simul_press", btn_press, 5'b11100);
    btn_async = '0;
    tick(15);

    // Random activity with occasional resets
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 7) == 0) btn_async[ch] = ~btn_async[ch];
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(1);
    end

    btn_async = '0;
    tick(12);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
